instr_mem_port: RTL
===================

# instr_mem_port

Instruction-memory responder for the single-cycle/multi-cycle MIPS datapath. It is the far end of the fetch interface:
- It accepts a byte fetch address from the fetch unit over a req/ready handshake.
- It returns the addressed 32-bit instruction word after a fixed number of wait states, with an instr_valid pulse.
- It flags misaligned and out-of-range fetches.
- A side load port lets the bench or boot logic write program words.

## Interface
Parameters:
- DEPTH_LOG2, 10: memory holds 2^DEPTH_LOG2 32-bit words.
- WAIT_STATES, 2: extra cycles between accept and response; legal range 0..15.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  reset, synchronous and active-low.
- req  in  1  fetch request.
- addr  in  32  byte fetch address; sampled when req && ready.
- ready  out  1  port can accept a request this cycle.
- instr_valid  out  1  one-cycle pulse; instr and fault are valid.
- instr  out  32  fetched word; 32'h0 on fault.
- fault  out  1  accompanies instr_valid; request was illegal.
- fault_code  out  2  01 = misaligned (addr[1:0] != 0), 10 = out of range (addr[31:2] >= 2^DEPTH_LOG2), 00 = none.
- load_en  in  1  write enable for the load port.
- load_addr  in  32  byte address for the load; addr[1:0] is ignored.
- load_data  in  32  word to write.
- fetch_count  out  16  number of responses issued; wraps modulo 2^16.

## Operation
- States are IDLE, WAIT and RESP. Wait counter width is 4 bits.
- ready = 1 in IDLE and RESP, 0 in WAIT and 0 while rst_n = 0.
- **Accept**: req && ready at an edge latches addr and fault classification.
  - If WAIT_STATES = 0, go to RESP.
  - Otherwise go to WAIT with cnt = WAIT_STATES - 1.
- **WAIT**: cnt decrements each edge. At the edge where cnt = 0, go to RESP and load the response registers.
- **Response registers**:
  - Non-fault: instr = mem[addr[DEPTH_LOG2+1:2]], fault = 0, fault_code = 00.
  - Fault: instr = 0, fault = 1, fault_code as defined under Interface. Misaligned has priority over out of range.
- **RESP**: instr_valid = 1 for this cycle only.
  - If req is also high, the new request is accepted at the same edge and the FSM proceeds as in Accept.
  - Otherwise go to IDLE.
- instr, fault and fault_code hold their last values when instr_valid = 0.
- fetch_count increments by 1 on every response, faulting or not, as RESP is entered. It wraps from 16'hFFFF to 0.
- **Load port**: when load_en = 1, mem[load_addr[DEPTH_LOG2+1:2]] <= load_data at the edge.
  - If load_addr[31:2] >= 2^DEPTH_LOG2, the write is dropped silently.
  - Loads are legal in any state.
- **Same-edge collision**: if a load and a response register load target the same word at the same edge, the response returns the OLD word. The written word is visible to any response loaded at a later edge.
- **Reset**:
  - Memory contents are not cleared.
  - Any in-flight request is discarded and produces no response.

## Timing
- Reset values (at the first edge with rst_n = 0): state IDLE, cnt 0, instr_valid 0, instr 32'h0, fault 0, fault_code 00, fetch_count 0. ready reads 0 during reset and 1 from the first cycle after rst_n rises.
- Latency: request accepted at edge e means instr_valid is high in the cycle after edge e + WAIT_STATES.
- Throughput:
  - WAIT_STATES = 0: one response per cycle with req held high, instr_valid continuously 1.
  - WAIT_STATES = W > 0: one response per W + 1 cycles.
- req while ready = 0 is ignored. The requester holds req and addr until it sees ready.

## Test plan
- **Reset**: hold rst_n = 0 for 3 cycles with req = 1 -> ready = 0, instr_valid = 0, fetch_count = 0 throughout. Release -> ready = 1 next cycle.
- **Single fetch, WAIT_STATES = 2**: load mem[5] = 32'h8C220004, then req with addr = 32'h14 accepted at edge e -> instr_valid high after edge e+2, instr = 32'h8C220004, fault = 0, fetch_count = 1, ready low for 2 cycles.
- **Streaming, WAIT_STATES = 0**: req held high with addr 0, 4, 8, 12 holding words A0..A3 -> instr_valid high 4 consecutive cycles with instr A0, A1, A2, A3 in order.
- **Faults**:
  - addr = 32'h16 -> fault = 1, fault_code = 01, instr = 0.
  - addr = 32'h1000 with DEPTH_LOG2 = 10 -> fault_code = 10.
  - addr = 32'h1002 -> fault_code = 01.
  - fetch_count increments for each fault.
- **Reset mid-operation**: accept with WAIT_STATES = 3, drive rst_n = 0 one cycle later -> no instr_valid ever appears for that request. Memory still returns previously loaded data afterwards.
- **Collision and wrap**:
  - Load mem[2] = 32'hDEAD at the same edge a response for addr 8 is loaded -> old mem[2] is returned. The next fetch of addr 8 returns 32'hDEAD.
  - 65536 responses -> fetch_count returns to 0.

Source files
------------

// File: rtl/instr_mem_port.sv
// Instruction-memory responder: accepts byte fetch addresses over req/ready and returns the word
// after WAIT_STATES cycles, flagging misaligned/out-of-range fetches; side port loads program words.
module instr_mem_port #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] addr,
  output logic        ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        fault,
  output logic [1:0]  fault_code,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [15:0] fetch_count
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [1:0]            code_q;
  logic                  valid_q;
  logic [31:0]           instr_q;
  logic                  fault_q;
  logic [1:0]            fcode_q;
  logic [15:0]           count_q;
  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic                  resp_load;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [DEPTH_LOG2-1:0] src_idx;
  logic [1:0]            acc_code;
  logic [1:0]            src_code;
  logic                  unused_load_lsbs;

  function automatic logic out_of_range(input logic [31:0] a);
    return (a[31:2] >> DEPTH_LOG2) != 30'd0;
  endfunction

  // Misaligned wins over out of range.
  function automatic logic [1:0] classify(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 2'b01;
    if (out_of_range(a)) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    ready     = rst_n && (state_q != S_WAIT);
    accept    = req && ready;
    acc_idx   = addr[DEPTH_LOG2+1:2];
    acc_code  = classify(addr);
    resp_load = 1'b0;
    src_idx   = idx_q;
    src_code  = code_q;
    if (accept && (WAIT_STATES == 0)) begin
      resp_load = 1'b1;
      src_idx   = acc_idx;
      src_code  = acc_code;
    end else if ((state_q == S_WAIT) && (cnt_q == 4'd0)) begin
      resp_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      code_q  <= 2'b00;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      fault_q <= 1'b0;
      fcode_q <= 2'b00;
      count_q <= 16'd0;
    end else begin
      valid_q <= resp_load;
      // Memory read sees the pre-edge contents, so a same-edge load returns the old word.
      if (resp_load) begin
        instr_q <= (src_code == 2'b00) ? mem[src_idx] : 32'h0;
        fault_q <= (src_code != 2'b00);
        fcode_q <= src_code;
        count_q <= count_q + 16'd1;
      end
      case (state_q)
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: begin
          if (accept) begin
            idx_q  <= acc_idx;
            code_q <= acc_code;
            if (WAIT_STATES == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && !out_of_range(load_addr)) mem[load_addr[DEPTH_LOG2+1:2]] <= load_data;
  end

  assign unused_load_lsbs = ^load_addr[1:0];
  assign instr_valid      = valid_q;
  assign instr            = instr_q;
  assign fault            = fault_q;
  assign fault_code       = fcode_q;
  assign fetch_count      = count_q;
endmodule
